// File: rtl/blit_pkg.sv
// Shared frame-buffer geometry and blitter state encoding, common to the
// sprite blitter and the display-side ROM readers.
package blit_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int FB_AW    = 17;
    localparam int SRC_AW   = 16;
    localparam int INDEX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/blit_raster_gen.sv
// Raster walker: walks sprite pixels in row-major order and produces the ROM
// address, frame-buffer address and on-screen flag for the pixel being issued.
module blit_raster_gen
    import blit_pkg::*;
#(
    parameter int SCREEN_W = blit_pkg::SCREEN_W,
    parameter int SCREEN_H = blit_pkg::SCREEN_H,
    parameter int FB_AW    = blit_pkg::FB_AW,
    parameter int SRC_AW   = blit_pkg::SRC_AW
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [8:0]        dst_x,
    input  logic [7:0]        dst_y,
    input  logic [8:0]        spr_w,
    input  logic [7:0]        spr_h,
    output logic [SRC_AW-1:0] src_addr,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              clip_ok,
    output logic              last
);

    logic [8:0]        i;
    logic [7:0]        j;
    logic [8:0]        w_q;
    logic [7:0]        h_q;
    logic [8:0]        x0_q;
    logic [SRC_AW-1:0] src_row;
    logic [FB_AW-1:0]  fb_row;
    logic [9:0]        x_cur;
    logic [9:0]        y_cur;
    logic              row_end;
    logic [FB_AW-1:0]  origin_row;
    logic [SRC_AW-1:0] next_src_row;
    logic [FB_AW-1:0]  next_fb_row;

    assign row_end      = (i == w_q - 9'd1);
    assign last         = row_end && (j == h_q - 8'd1);
    // 10-bit screen coordinates never wrap, so off-screen pixels stay off-screen.
    assign clip_ok      = (x_cur < 10'(SCREEN_W)) && (y_cur < 10'(SCREEN_H));
    // Constant-coefficient product: reduces to a shift-add, computed once per request.
    assign origin_row   = FB_AW'(dst_y) * FB_AW'(SCREEN_W);
    assign next_src_row = src_row + SRC_AW'(w_q);
    assign next_fb_row  = fb_row + FB_AW'(SCREEN_W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            i        <= '0;
            j        <= '0;
            w_q      <= '0;
            h_q      <= '0;
            x0_q     <= '0;
            src_row  <= '0;
            fb_row   <= '0;
            src_addr <= '0;
            fb_addr  <= '0;
            x_cur    <= '0;
            y_cur    <= '0;
        end else if (load) begin
            i        <= '0;
            j        <= '0;
            w_q      <= spr_w;
            h_q      <= spr_h;
            x0_q     <= dst_x;
            src_row  <= src_base;
            src_addr <= src_base;
            fb_row   <= origin_row;
            fb_addr  <= origin_row + FB_AW'(dst_x);
            x_cur    <= {1'b0, dst_x};
            y_cur    <= {2'b00, dst_y};
        end else if (step) begin
            if (row_end) begin
                i        <= '0;
                j        <= j + 8'd1;
                src_row  <= next_src_row;
                src_addr <= next_src_row;
                fb_row   <= next_fb_row;
                fb_addr  <= next_fb_row + FB_AW'(x0_q);
                x_cur    <= {1'b0, x0_q};
                y_cur    <= y_cur + 10'd1;
            end else begin
                i        <= i + 9'd1;
                src_addr <= src_addr + SRC_AW'(1);
                fb_addr  <= fb_addr + FB_AW'(1);
                x_cur    <= x_cur + 10'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a 4-bit palette-index sprite from a synchronous ROM into the frame
// buffer at one pixel per clock, skipping transparent pixels and clipping at the edges.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int                 SCREEN_W    = blit_pkg::SCREEN_W,
    parameter int                 SCREEN_H    = blit_pkg::SCREEN_H,
    parameter int                 INDEX_W     = blit_pkg::INDEX_W,
    parameter int                 FB_AW       = blit_pkg::FB_AW,
    parameter int                 SRC_AW      = blit_pkg::SRC_AW,
    parameter logic [INDEX_W-1:0] TRANSPARENT = '0
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SRC_AW-1:0]  src_base,
    input  logic [8:0]         dst_x,
    input  logic [7:0]         dst_y,
    input  logic [8:0]         spr_w,
    input  logic [7:0]         spr_h,
    output logic               busy,
    output logic               done,
    output logic [SRC_AW-1:0]  src_addr,
    input  logic [INDEX_W-1:0] src_data,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [INDEX_W-1:0] fb_data
);

    blit_state_t      state;
    logic             zero_size;
    logic             load;
    logic             step;
    logic             last;
    logic             clip_ok;
    logic [FB_AW-1:0] pix_addr;
    logic             pipe_valid;
    logic             pipe_clip;

    assign zero_size = (spr_w == 9'd0) || (spr_h == 8'd0);
    assign load      = (state == IDLE) && start && !zero_size;
    assign step      = (state == RUN) && !last;

    blit_raster_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .FB_AW    (FB_AW),
        .SRC_AW   (SRC_AW)
    ) u_raster (
        .Clk      (Clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .src_base (src_base),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .spr_w    (spr_w),
        .spr_h    (spr_h),
        .src_addr (src_addr),
        .fb_addr  (pix_addr),
        .clip_ok  (clip_ok),
        .last     (last)
    );

    // ROM data arrives in the cycle after its address, so the write strobe is
    // formed from the pipeline stage and the live ROM data together.
    assign fb_we   = pipe_valid && pipe_clip && (src_data != TRANSPARENT);
    assign fb_data = fb_we ? src_data : '0;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_clip  <= 1'b0;
            fb_addr    <= '0;
        end else begin
            pipe_valid <= (state == RUN);
            if (state == RUN) begin
                pipe_clip <= clip_ok;
                fb_addr   <= pix_addr;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (zero_size) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last) state <= DRAIN;
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a behavioural synchronous ROM feeds the
// DUT and every write, busy and done cycle is logged against hand-worked values.
module tb_sprite_blitter;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_base = '0;
    logic [8:0]  dst_x = '0;
    logic [7:0]  dst_y = '0;
    logic [8:0]  spr_w = '0;
    logic [7:0]  spr_h = '0;
    logic        busy;
    logic        done;
    logic [15:0] src_addr;
    logic [3:0]  src_data;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [3:0]  fb_data;

    logic [3:0]  rom [0:65535];

    int checks = 0;
    int errors = 0;

    int          wr_cyc [$];
    int          wr_addr [$];
    int          wr_data [$];
    int          done_cyc;
    int          busy_n;
    int          busy_first;
    int          busy_last;
    logic [15:0] src_log [0:15];

    sprite_blitter dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .src_base (src_base),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .spr_w    (spr_w),
        .spr_h    (spr_h),
        .busy     (busy),
        .done     (done),
        .src_addr (src_addr),
        .src_data (src_data),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) src_data <= rom[src_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input int cyc,
                            input int addr, input int data);
        if (idx < wr_cyc.size()) begin
            check({tag, "_cyc"}, wr_cyc[idx], cyc);
            check({tag, "_addr"}, wr_addr[idx], addr);
            check({tag, "_data"}, wr_data[idx], data);
        end else begin
            check({tag, "_missing"}, 0, 1);
        end
    endtask

    // Issues one request at the next falling edge; cycle k is the one after edge k.
    task automatic run_blit(input logic [15:0] base, input logic [8:0] x, input logic [7:0] y,
                            input logic [8:0] w, input logic [7:0] h,
                            input int restart_cyc, input int rst_cyc, input int limit);
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc   = -1;
        busy_n     = 0;
        busy_first = -1;
        busy_last  = -1;
        for (int k = 0; k < 16; k++) src_log[k] = '0;
        @(negedge Clk);
        src_base = base;
        dst_x    = x;
        dst_y    = y;
        spr_w    = w;
        spr_h    = h;
        start    = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge Clk);
            if (fb_we) begin
                wr_cyc.push_back(k);
                wr_addr.push_back(int'(fb_addr));
                wr_data.push_back(int'(fb_data));
            end
            if (busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (k < 16) src_log[k] = src_addr;
            if (done && done_cyc < 0) done_cyc = k;
            if (rst_cyc > 0 && k == rst_cyc + 1) begin
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_fb_we", fb_we, 0);
                check("rst_fb_addr", fb_addr, 0);
                check("rst_fb_data", fb_data, 0);
                check("rst_src_addr", src_addr, 0);
                reset = 1'b1;
            end
            if (k == 1) begin
                start    = 1'b0;
                src_base = 16'hBEEF;
                dst_x    = 9'd7;
                dst_y    = 8'd3;
                spr_w    = 9'd5;
                spr_h    = 8'd5;
            end
            if (k == restart_cyc) start = 1'b1;
            else if (k == restart_cyc + 1) start = 1'b0;
            if (rst_cyc > 0 && k == rst_cyc) reset = 1'b0;
            if (done_cyc > 0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int late;
        for (int a = 0; a < 65536; a++) rom[a] = 4'((a % 15) + 1);
        rom[100] = 4'd1; rom[101] = 4'd2; rom[102] = 4'd3; rom[103] = 4'd4;
        rom[200] = 4'd5; rom[201] = 4'd0; rom[202] = 4'd7;
        for (int a = 0; a < 8; a++) rom[300 + a] = 4'(9 + a);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_fb_we", fb_we, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_data", fb_data, 0);
        check("reset_src_addr", src_addr, 0);
        reset = 1'b1;

        // 2x2 at (10,5)
        run_blit(16'd100, 9'd10, 8'd5, 9'd2, 8'd2, 0, 0, 20);
        for (int n = 0; n < 4; n++) check($sformatf("t1_src%0d", n), src_log[1 + n], 100 + n);
        check("t1_nwr", wr_cyc.size(), 4);
        check_wr("t1_w0", 0, 2, 1610, 1);
        check_wr("t1_w1", 1, 3, 1611, 2);
        check_wr("t1_w2", 2, 4, 1930, 3);
        check_wr("t1_w3", 3, 5, 1931, 4);
        check("t1_done", done_cyc, 6);
        check("t1_busy_first", busy_first, 1);
        check("t1_busy_last", busy_last, 5);

        // 3x1 with a transparent middle pixel
        run_blit(16'd200, 9'd0, 8'd0, 9'd3, 8'd1, 0, 0, 20);
        check("t2_nwr", wr_cyc.size(), 2);
        check_wr("t2_w0", 0, 2, 0, 5);
        check_wr("t2_w1", 1, 4, 2, 7);
        check("t2_done", done_cyc, 5);

        // 4x2 at the bottom-right corner
        run_blit(16'd300, 9'd318, 8'd239, 9'd4, 8'd2, 0, 0, 20);
        check("t3_nwr", wr_cyc.size(), 2);
        check_wr("t3_w0", 0, 2, 76798, 9);
        check_wr("t3_w1", 1, 3, 76799, 10);
        check("t3_done", done_cyc, 10);

        // zero width and zero height
        run_blit(16'd100, 9'd10, 8'd5, 9'd0, 8'd3, 0, 0, 10);
        check("t4w_done", done_cyc, 1);
        check("t4w_busy", busy_n, 0);
        check("t4w_nwr", wr_cyc.size(), 0);
        run_blit(16'd100, 9'd10, 8'd5, 9'd4, 8'd0, 0, 0, 10);
        check("t4h_done", done_cyc, 1);
        check("t4h_busy", busy_n, 0);
        check("t4h_nwr", wr_cyc.size(), 0);

        // second start mid-RUN, then a back-to-back request
        run_blit(16'd100, 9'd10, 8'd5, 9'd2, 8'd2, 2, 0, 20);
        check("t5_nwr", wr_cyc.size(), 4);
        check_wr("t5_w0", 0, 2, 1610, 1);
        check_wr("t5_w3", 3, 5, 1931, 4);
        check("t5_done", done_cyc, 6);
        run_blit(16'd200, 9'd0, 8'd0, 9'd3, 8'd1, 0, 0, 20);
        check("t5b_nwr", wr_cyc.size(), 2);
        check_wr("t5b_w1", 1, 4, 2, 7);
        check("t5b_done", done_cyc, 5);

        // reset asserted during an 8x8 blit
        run_blit(16'd400, 9'd0, 8'd0, 9'd8, 8'd8, 0, 5, 74);
        late = 0;
        foreach (wr_cyc[q]) if (wr_cyc[q] > 5) late++;
        check("t6_late_writes", late, 0);
        check("t6_early_writes", wr_cyc.size(), 4);
        check("t6_no_done", done_cyc, -1);
        check("t6_busy_last", busy_last, 5);

        // a fresh request after reset behaves normally
        run_blit(16'd100, 9'd10, 8'd5, 9'd2, 8'd2, 0, 0, 20);
        check("t7_nwr", wr_cyc.size(), 4);
        check_wr("t7_w0", 0, 2, 1610, 1);
        check("t7_done", done_cyc, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Writer-side counterpart to the screen ROM readers. It copies a rectangular 4-bit palette-index sprite from a synchronous sprite ROM into the 320×240 on-chip frame buffer that the display path scans out at 2× scale. The copy is a single-issue raster pipeline at one pixel per clock, with transparency skipping and screen-edge clipping. It sits between game logic, which issues start requests, and the frame-buffer RAM write port.

## Interface
Parameters:
- SCREEN_W, 320, frame-buffer width in pixels
- SCREEN_H, 240, frame-buffer height in pixels
- INDEX_W, 4, palette index width
- FB_AW, 17, frame-buffer address width (76800 words)
- SRC_AW, 16, sprite-ROM address width
- TRANSPARENT, 4'h0, index that is never written

Ports:
- Clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-low
- start  in  1  request pulse, sampled only in IDLE
- src_base  in  SRC_AW  ROM address of sprite pixel (0,0)
- dst_x  in  9  destination column of sprite origin
- dst_y  in  8  destination row of sprite origin
- spr_w  in  9  sprite width in pixels
- spr_h  in  8  sprite height in pixels
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- src_addr  out  SRC_AW  ROM read address; data returns one cycle later
- src_data  in  INDEX_W  ROM read data
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  FB_AW  write address = y*SCREEN_W + x
- fb_data  out  INDEX_W  write data

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1: latch all request inputs. If spr_w=0 or spr_h=0, go to DONE. Otherwise go to RUN.
- RUN: issue src_addr for pixel n, raster order, column i fastest, n = 0..N-1 where N = spr_w*spr_h.
  - src_addr = src_base + j*spr_w + i, modulo 2^SRC_AW.
  - Addresses come from running row accumulators: src row base += spr_w, fb row base += SCREEN_W. No multipliers.
  - After pixel N-1 is issued, go to DRAIN.
- Write stage, one cycle after issue:
  - fb_we=1 iff src_data ≠ TRANSPARENT and dst_x+i < SCREEN_W and dst_y+j < SCREEN_H.
  - Clip sums use 10-bit arithmetic, with no wrap.
  - fb_addr and fb_data are valid whenever fb_we=1.
- DRAIN: carries the final write, then goes to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored. It is not queued.
- Request inputs may change after the start cycle without effect.
- reset low: state returns to IDLE on the next edge. Any in-flight write is dropped; no fb_we is issued after reset is sampled.

## Timing
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, src_addr=0.
- start is sampled at edge 0.
- For pixel n:
  - src_addr is valid in cycle 1+n.
  - The fb write occurs in cycle 2+n.
- Last write in cycle N+1 (DRAIN). done in cycle N+2. busy is high for cycles 1..N+1.
- Zero-size request: done in cycle 1, busy never asserts, no writes.
- Throughput is one pixel per clock. Back-to-back requests are possible: the next start is accepted in the cycle after done.

## Structure
- Package blit_pkg holds:
  - state enum blit_state_t {IDLE, RUN, DRAIN, DONE}
  - SCREEN_W, SCREEN_H, FB_AW, SRC_AW constants, shared with the display-side ROM readers
- One sub-module, blit_raster_gen:
  - i/j counters, row-base accumulators, and clip flags
  - signals last-pixel to the FSM
- Top level holds:
  - the FSM
  - a one-stage pipeline register for fb address, clip flag and valid, aligned with the ROM latency

## Test plan
- 2×2 sprite at (10,5), src_base=100, ROM = {1,2,3,4} → src_addr 100..103 in cycles 1–4. Writes land at addresses 1610, 1611, 1930, 1931 with data 1, 2, 3, 4 in cycles 2–5. done in cycle 6.
- 3×1 sprite with ROM = {5,0,7} → exactly two writes (5, then 7). No fb_we in the cycle for the transparent pixel. done timing is unchanged.
- 4×2 sprite at (318,239) → only (318,239) and (319,239) are written, i.e. addresses 76798 and 76799. No write wraps into row 0.
- spr_w=0 → done in cycle 1, busy=0 throughout, zero writes.
- start pulsed again mid-RUN → ignored, and the write count stays N. A start issued the cycle after done is accepted.
- reset driven low during RUN of an 8×8 blit → all outputs 0 from the next edge, state IDLE, and no subsequent fb_we until a new start.
